// File: rtl/shift_normalizer_if.sv
// rtl/shift_normalizer_if.sv - start/done handshake bundle between a controller and shift_normalizer
//
// Purpose: groups the request (start/mode/din) and result (busy/done/dout/shamt/degen)
// signals of the normalizer so they travel as one port.
// Signals:
//   start  request, sampled by the normalizer only while idle
//   mode   0 = unsigned normalize, 1 = signed normalize
//   din    WIDTH-bit operand
//   busy   normalizer is not idle
//   done   one-cycle result-valid pulse
//   dout   normalized value
//   shamt  number of left shifts applied
//   degen  operand cannot be normalized
// Modports: master = controller side, slave = normalizer side.
interface shift_normalizer_if #(
  parameter int WIDTH = 16
);
  localparam int SW = $clog2(WIDTH);

  logic             start;
  logic             mode;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic [SW-1:0]    shamt;
  logic             degen;

  modport master (
    output start, mode, din,
    input  busy, done, dout, shamt, degen
  );

  modport slave (
    input  start, mode, din,
    output busy, done, dout, shamt, degen
  );
endinterface

// File: rtl/shift_normalizer.sv
// rtl/shift_normalizer.sv - sequential normalizer recovering the left-shift amount of an operand
//
// Purpose: shifts a latched operand left one bit per cycle until it is normalized,
// then reports the normalized value and the shift count with a one-cycle done pulse.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    shift_normalizer_if slave modport (start/mode/din in; busy/done/dout/shamt/degen out)
// All outputs are registered.
module shift_normalizer #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  shift_normalizer_if.slave    bus
);
  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [SW-1:0]    shamt_q, shamt_d;
  logic             degen_q, degen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             degen_in;
  logic             norm;

  // Operands that no amount of shifting can normalize go straight to DONE.
  assign degen_in = bus.mode ? ((bus.din == '0) || (bus.din == '1)) : (bus.din == '0);

  // Signed normalization: sign bit differs from the bit below it.
  assign norm = mode_q ? (r_q[WIDTH-1] ^ r_q[WIDTH-2]) : r_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    mode_d  = mode_q;
    dout_d  = dout_q;
    shamt_d = shamt_q;
    degen_d = degen_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mode_d  = bus.mode;
          shamt_d = '0;
          if (degen_in) begin
            dout_d  = bus.din;
            degen_d = 1'b1;
            state_d = DONE;
          end else begin
            r_d     = bus.din;
            degen_d = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (norm) begin
          dout_d  = r_q;
          state_d = DONE;
        end else begin
          r_d     = {r_q[WIDTH-2:0], 1'b0};
          shamt_d = shamt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      mode_q  <= 1'b0;
      dout_q  <= '0;
      shamt_q <= '0;
      degen_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      mode_q  <= mode_d;
      dout_q  <= dout_d;
      shamt_q <= shamt_d;
      degen_q <= degen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.dout  = dout_q;
  assign bus.shamt = shamt_q;
  assign bus.degen = degen_q;
endmodule
